store_queue: RTL and testbench

Sits directly downstream of the address-generation stage. Each store uop arriving with a computed address and data is buffered in a slot indexed by its store sequence number (sqN). Store data is forwarded byte-wise to younger loads. Entries are dropped on branch mispredict, and committed stores drain in order to the data-memory write port through a one-entry output register.

---
 rtl/store_queue_pkg.sv | 32 +++
 rtl/store_queue_if.sv | 46 ++++
 rtl/store_queue_fwd_select.sv | 37 +++
 rtl/store_queue.sv | 132 +++++++++++++
 tb/tb_store_queue.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_queue_pkg.sv
// Shared store-queue definitions: default geometry, the entry record and
// wrap-safe sequence-number age compares used by the address stage and rename.
package store_queue_pkg;

  localparam int SQ_NUM_ENTRIES = 8;
  localparam int SQ_SQN_W       = 7;

  typedef logic [SQ_SQN_W-1:0] sqn_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    sqn_t        sqn;
  } sq_entry_t;

  // a is older than b: signed(a - b) < 0
  function automatic logic sqn_older(sqn_t a, sqn_t b);
    sqn_t d;
    d = a - b;
    return d[SQ_SQN_W-1];
  endfunction

  // a is younger than b: signed(a - b) > 0
  function automatic logic sqn_younger(sqn_t a, sqn_t b);
    sqn_t d;
    d = a - b;
    return !d[SQ_SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Store-queue port bundle: store uops in, commit/flush control, load forwarding
// lookup and the data-memory write port.
interface store_queue_if;
  import store_queue_pkg::*;

  logic        IN_valid;
  logic [31:0] IN_addr;
  logic [31:0] IN_data;
  logic [3:0]  IN_wmask;
  sqn_t        IN_sqN;
  logic        IN_exception;
  sqn_t        IN_comSqN;
  logic        IN_branchValid;
  sqn_t        IN_branchSqN;
  logic        IN_ldValid;
  logic [31:0] IN_ldAddr;
  sqn_t        IN_ldSqN;
  logic [3:0]  OUT_fwdMask;
  logic [31:0] OUT_fwdData;
  // Write port: a request transfers on a cycle where OUT_memValid and
  // IN_memReady are both 1; while valid and not ready, addr/data/mask hold.
  logic        OUT_memValid;
  logic [29:0] OUT_memAddr;
  logic [31:0] OUT_memData;
  logic [3:0]  OUT_memMask;
  logic        IN_memReady;
  sqn_t        OUT_baseSqN;
  logic        OUT_empty;

  modport master (
    output IN_valid, IN_addr, IN_data, IN_wmask, IN_sqN, IN_exception,
    output IN_comSqN, IN_branchValid, IN_branchSqN,
    output IN_ldValid, IN_ldAddr, IN_ldSqN, IN_memReady,
    input  OUT_fwdMask, OUT_fwdData, OUT_memValid, OUT_memAddr,
    input  OUT_memData, OUT_memMask, OUT_baseSqN, OUT_empty
  );

  modport slave (
    input  IN_valid, IN_addr, IN_data, IN_wmask, IN_sqN, IN_exception,
    input  IN_comSqN, IN_branchValid, IN_branchSqN,
    input  IN_ldValid, IN_ldAddr, IN_ldSqN, IN_memReady,
    output OUT_fwdMask, OUT_fwdData, OUT_memValid, OUT_memAddr,
    output OUT_memData, OUT_memMask, OUT_baseSqN, OUT_empty
  );

endinterface

// File: rtl/store_queue_fwd_select.sv
// One byte lane of store-to-load forwarding: picks the youngest matching queue
// entry, falling back to the output register, which is always the oldest.
module sq_fwd_select
  import store_queue_pkg::*;
#(
  parameter int N = SQ_NUM_ENTRIES
) (
  input  logic [N-1:0]               cand_vld,
  input  logic [N-1:0][SQ_SQN_W-1:0] cand_age,
  input  logic [N-1:0][7:0]          cand_byte,
  input  logic                       out_vld,
  input  logic [7:0]                 out_byte,
  output logic                       hit,
  output logic [7:0]                 sel_byte
);

  logic                found;
  logic [SQ_SQN_W-1:0] best_age;
  logic [7:0]          best_byte;

  always_comb begin
    found     = 1'b0;
    best_age  = '0;
    best_byte = '0;
    // age is the offset from baseSqN, so the largest offset is the youngest
    for (int i = 0; i < N; i++) begin
      if (cand_vld[i] && (!found || $signed(cand_age[i]) > $signed(best_age))) begin
        found     = 1'b1;
        best_age  = cand_age[i];
        best_byte = cand_byte[i];
      end
    end
    hit      = found || out_vld;
    sel_byte = found ? best_byte : (out_vld ? out_byte : 8'h00);
  end

endmodule

// File: rtl/store_queue.sv
// Store queue: sqN-indexed store buffer with byte forwarding to younger loads,
// mispredict flush and in-order drain through a one-entry memory write register.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = SQ_NUM_ENTRIES
) (
  input logic         clk,
  input logic         rst,
  store_queue_if.slave sq
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  sq_entry_t                            entries [NUM_ENTRIES];
  sqn_t                                 base_sqn;
  logic                                 mem_valid;
  logic [29:0]                          mem_addr;
  logic [31:0]                          mem_data;
  logic [3:0]                           mem_mask;
  logic [IDX_W-1:0]                     head_idx, wr_idx;
  sq_entry_t                            head;
  logic [NUM_ENTRIES-1:0]               kill, valid_vec;
  logic                                 out_free, drain, drain_load, wr_drop, wr_en;
  logic [29:0]                          ld_word;
  logic [3:0][NUM_ENTRIES-1:0]          cand_vld;
  logic [NUM_ENTRIES-1:0][SQ_SQN_W-1:0] cand_age;
  logic [3:0][NUM_ENTRIES-1:0][7:0]     cand_byte;
  logic [3:0]                           out_vld, lane_hit;
  logic [3:0][7:0]                      lane_byte;
  logic                                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{sq.IN_addr[1:0], sq.IN_ldAddr[1:0]};

  assign head_idx   = base_sqn[IDX_W-1:0];
  assign wr_idx     = sq.IN_sqN[IDX_W-1:0];
  assign head       = entries[head_idx];
  assign out_free   = !mem_valid || sq.IN_memReady;
  assign drain      = head.valid && sqn_older(head.sqn, sq.IN_comSqN) && out_free;
  assign drain_load = drain && (head.mask != 4'd0);
  assign wr_drop    = sq.IN_branchValid && sqn_younger(sq.IN_sqN, sq.IN_branchSqN)
                      && !sqn_older(sq.IN_sqN, sq.IN_comSqN);
  assign wr_en      = sq.IN_valid && !wr_drop;

  always_comb begin
    kill      = '0;
    valid_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      kill[i] = sq.IN_branchValid && entries[i].valid
                && sqn_younger(entries[i].sqn, sq.IN_branchSqN)
                && !sqn_older(entries[i].sqn, sq.IN_comSqN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
      base_sqn  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_mask  <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (kill[i] || (drain && head_idx == IDX_W'(i))) entries[i].valid <= 1'b0;
      end
      if (wr_en) begin
        entries[wr_idx] <= '{valid: 1'b1,
                             addr:  sq.IN_addr[31:2],
                             data:  sq.IN_data,
                             mask:  sq.IN_exception ? 4'd0 : sq.IN_wmask,
                             sqn:   sq.IN_sqN};
      end
      // faulted / empty stores retire here without a memory request
      if (drain) base_sqn <= base_sqn + sqn_t'(1);
      if (drain_load) begin
        mem_valid <= 1'b1;
        mem_addr  <= head.addr;
        mem_data  <= head.data;
        mem_mask  <= head.mask;
      end else if (sq.IN_memReady) begin
        mem_valid <= 1'b0;
      end
    end
  end

  wr_slot_free: assert property (@(posedge clk) disable iff (rst) wr_en |-> !entries[wr_idx].valid);

  assign ld_word = sq.IN_ldAddr[31:2];

  always_comb begin
    cand_vld  = '0;
    cand_age  = '0;
    cand_byte = '0;
    out_vld   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand_age[i] = entries[i].sqn - base_sqn;
      for (int b = 0; b < 4; b++) begin
        cand_vld[b][i]  = sq.IN_ldValid && entries[i].valid && entries[i].mask[b]
                          && sqn_older(entries[i].sqn, sq.IN_ldSqN)
                          && (entries[i].addr == ld_word);
        cand_byte[b][i] = entries[i].data[8*b +: 8];
      end
    end
    for (int b = 0; b < 4; b++) begin
      out_vld[b] = sq.IN_ldValid && mem_valid && mem_mask[b] && (mem_addr == ld_word);
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    sq_fwd_select #(.N(NUM_ENTRIES)) u_sel (
      .cand_vld (cand_vld[b]),
      .cand_age (cand_age),
      .cand_byte(cand_byte[b]),
      .out_vld  (out_vld[b]),
      .out_byte (mem_data[8*b +: 8]),
      .hit      (lane_hit[b]),
      .sel_byte (lane_byte[b])
    );
  end

  assign sq.OUT_fwdMask  = lane_hit;
  assign sq.OUT_fwdData  = lane_byte;
  assign sq.OUT_memValid = mem_valid;
  assign sq.OUT_memAddr  = mem_addr;
  assign sq.OUT_memData  = mem_data;
  assign sq.OUT_memMask  = mem_mask;
  assign sq.OUT_baseSqN  = base_sqn;
  assign sq.OUT_empty    = (valid_vec == '0) && !mem_valid;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios then random traffic, every cycle
// compared against a sqN-indexed behavioural model with a memory-write scoreboard.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int N   = SQ_NUM_ENTRIES;
  localparam int MOD = 1 << SQ_SQN_W;
  localparam int W   = 66;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_queue_if sq_if ();
  store_queue #(.NUM_ENTRIES(N)) dut (.clk(clk), .rst(rst), .sq(sq_if));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit        v;
    bit [29:0] a;
    bit [31:0] d;
    bit [3:0]  m;
  } mst_t;

  mst_t         st [MOD];
  int           m_base;
  bit           m_ov;
  bit [29:0]    m_oa;
  bit [31:0]    m_od;
  bit [3:0]     m_om;
  logic [W-1:0] exp_q[$];
  int           alloc, com;

  function automatic int sdiff(int a, int b);
    int d;
    d = (a - b) % MOD;
    if (d < 0) d += MOD;
    if (d >= MOD / 2) d -= MOD;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int s = 0; s < MOD; s++) st[s].v = 1'b0;
    m_base = 0; m_ov = 1'b0; m_oa = '0; m_od = '0; m_om = '0;
    exp_q.delete();
  endtask

  function automatic bit model_empty();
    for (int s = 0; s < MOD; s++) if (st[s].v) return 1'b0;
    return !m_ov;
  endfunction

  task automatic model_fwd(output bit [3:0] fm, output bit [31:0] fd);
    bit [29:0] la;
    int        s;
    fm = '0; fd = '0;
    if (!sq_if.IN_ldValid) return;
    la = sq_if.IN_ldAddr[31:2];
    for (int b = 0; b < 4; b++) begin
      if (m_ov && m_oa == la && m_om[b]) begin
        fm[b] = 1'b1; fd[8*b +: 8] = m_od[8*b +: 8];
      end
      // walk oldest to youngest so the last match wins
      for (int k = 0; k < MOD; k++) begin
        s = (m_base + k) % MOD;
        if (st[s].v && sdiff(s, int'(sq_if.IN_ldSqN)) < 0 && st[s].a == la && st[s].m[b]) begin
          fm[b] = 1'b1; fd[8*b +: 8] = st[s].d[8*b +: 8];
        end
      end
    end
  endtask

  task automatic model_step();
    int  c, br, sn;
    bit  rdy, drained, loaded;
    if (rst) begin model_reset(); return; end
    c   = int'(sq_if.IN_comSqN);
    br  = int'(sq_if.IN_branchSqN);
    sn  = int'(sq_if.IN_sqN);
    rdy = sq_if.IN_memReady;
    drained = st[m_base].v && sdiff(m_base, c) < 0 && (!m_ov || rdy);
    loaded  = drained && st[m_base].m != 0;
    if (loaded) begin
      m_ov = 1'b1; m_oa = st[m_base].a; m_od = st[m_base].d; m_om = st[m_base].m;
      exp_q.push_back({m_oa, m_od, m_om});
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (drained) begin
      st[m_base].v = 1'b0;
      m_base = (m_base + 1) % MOD;
    end
    if (sq_if.IN_branchValid)
      for (int s = 0; s < MOD; s++)
        if (st[s].v && sdiff(s, br) > 0 && !(sdiff(s, c) < 0)) st[s].v = 1'b0;
    if (sq_if.IN_valid && !(sq_if.IN_branchValid && sdiff(sn, br) > 0 && !(sdiff(sn, c) < 0))) begin
      st[sn].v = 1'b1;
      st[sn].a = sq_if.IN_addr[31:2];
      st[sn].d = sq_if.IN_data;
      st[sn].m = sq_if.IN_exception ? 4'h0 : sq_if.IN_wmask;
    end
  endtask

  task automatic check_outputs();
    bit [3:0]     fm;
    bit [31:0]    fd;
    logic [W-1:0] e;
    model_fwd(fm, fd);
    chk("fwd_mask", W'(sq_if.OUT_fwdMask), W'(fm));
    chk("fwd_data", W'(sq_if.OUT_fwdData), W'(fd));
    chk("mem_valid", W'(sq_if.OUT_memValid), W'(m_ov));
    if (m_ov) chk("mem_req", {sq_if.OUT_memAddr, sq_if.OUT_memData, sq_if.OUT_memMask}, {m_oa, m_od, m_om});
    chk("base_sqn", W'(sq_if.OUT_baseSqN), W'(m_base));
    chk("empty", W'(sq_if.OUT_empty), W'(model_empty()));
    if (sq_if.OUT_memValid === 1'b1 && sq_if.IN_memReady && !rst) begin
      chk("sb_has_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_mem_write", {sq_if.OUT_memAddr, sq_if.OUT_memData, sq_if.OUT_memMask}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    sq_if.IN_valid       = 1'b0;
    sq_if.IN_exception   = 1'b0;
    sq_if.IN_branchValid = 1'b0;
    sq_if.IN_ldValid     = 1'b0;
  endtask

  task automatic put_store(input int sqn, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] m, input bit exc);
    sq_if.IN_valid     = 1'b1;
    sq_if.IN_sqN       = sqn_t'(sqn);
    sq_if.IN_addr      = addr;
    sq_if.IN_data      = data;
    sq_if.IN_wmask     = m;
    sq_if.IN_exception = exc;
  endtask

  task automatic set_com(input int c);
    com = c % MOD;
    sq_if.IN_comSqN = sqn_t'(com);
  endtask

  task automatic load(input logic [31:0] addr, input int lsqn);
    sq_if.IN_ldValid = 1'b1;
    sq_if.IN_ldAddr  = addr;
    sq_if.IN_ldSqN   = sqn_t'(lsqn);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  span, br, new_alloc, ls;
    bit  wrote;

    // ---------------- reset ----------------
    rst = 1'b1;
    clear_in();
    sq_if.IN_addr = '0; sq_if.IN_data = '0; sq_if.IN_wmask = '0; sq_if.IN_sqN = '0;
    sq_if.IN_branchSqN = '0; sq_if.IN_ldAddr = '0; sq_if.IN_ldSqN = '0;
    sq_if.IN_memReady = 1'b1;
    set_com(0);
    @(posedge clk); #1;
    model_reset();
    chk("rst_mem_valid", W'(sq_if.OUT_memValid), W'(0));
    chk("rst_mem_req", {sq_if.OUT_memAddr, sq_if.OUT_memData, sq_if.OUT_memMask}, '0);
    chk("rst_base", W'(sq_if.OUT_baseSqN), W'(0));
    chk("rst_empty", W'(sq_if.OUT_empty), W'(1));
    chk("rst_fwd", W'({sq_if.OUT_fwdMask, sq_if.OUT_fwdData}), W'(0));
    tick();
    rst = 1'b0;

    // ---------------- in-order drain of sqN 0..3 ----------------
    for (int i = 0; i < 4; i++) begin
      clear_in(); put_store(i, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0); tick();
    end
    clear_in(); set_com(4); tick();
    chk("drain_latency_valid", W'(sq_if.OUT_memValid), W'(1));
    chk("drain_first_addr", W'(sq_if.OUT_memAddr), W'(30'h40));
    repeat (5) tick();
    chk("drain4_base", W'(sq_if.OUT_baseSqN), W'(4));
    chk("drain4_empty", W'(sq_if.OUT_empty), W'(1));

    // ---------------- byte forwarding ----------------
    clear_in(); put_store(4, 32'h200, 32'h11223344, 4'hF, 1'b0); tick();
    clear_in(); put_store(5, 32'h200, 32'hAABBCCDD, 4'h3, 1'b0); tick();
    clear_in();
    load(32'h200, 6);
    chk("fwd_two_mask", W'(sq_if.OUT_fwdMask), W'(4'hF));
    chk("fwd_two_data", W'(sq_if.OUT_fwdData), W'(32'h1122CCDD));
    load(32'h200, 5);
    chk("fwd_one_data", W'(sq_if.OUT_fwdData), W'(32'h11223344));
    load(32'h200, 4);
    chk("fwd_none_mask", W'(sq_if.OUT_fwdMask), W'(0));
    load(32'h204, 6);
    chk("fwd_addr_miss", W'({sq_if.OUT_fwdMask, sq_if.OUT_fwdData}), W'(0));
    tick();

    // ---------------- memory back-pressure ----------------
    clear_in(); sq_if.IN_memReady = 1'b0; set_com(6); tick();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      chk("stall_valid", W'(sq_if.OUT_memValid), W'(1));
      chk("stall_req", W'({sq_if.OUT_memAddr, sq_if.OUT_memData}), W'({30'h80, 32'h11223344}));
      load(32'h200, 5);
      chk("fwd_from_outreg", W'(sq_if.OUT_fwdData), W'(32'h11223344));
      load(32'h200, 6);
      chk("fwd_outreg_plus_q", W'(sq_if.OUT_fwdData), W'(32'h1122CCDD));
      tick();
    end
    clear_in(); sq_if.IN_memReady = 1'b1;
    repeat (3) tick();
    chk("stall_release_base", W'(sq_if.OUT_baseSqN), W'(6));

    // ---------------- mispredict flush ----------------
    for (int s = 6; s < 10; s++) begin
      clear_in(); put_store(s, 32'h300 + 32'(4 * s), $urandom, 4'($urandom_range(1, 15)), 1'b0); tick();
    end
    clear_in(); sq_if.IN_branchValid = 1'b1; sq_if.IN_branchSqN = sqn_t'(7); tick();
    clear_in(); set_com(8);
    repeat (4) tick();
    chk("flush_base", W'(sq_if.OUT_baseSqN), W'(8));
    chk("flush_empty", W'(sq_if.OUT_empty), W'(1));

    // ---------------- faulted store retires silently ----------------
    clear_in(); put_store(8, 32'h400, 32'hDEAD0008, 4'hF, 1'b1); tick();
    clear_in(); set_com(9); tick();
    chk("fault_base", W'(sq_if.OUT_baseSqN), W'(9));
    chk("fault_no_req", W'(sq_if.OUT_memValid), W'(0));

    // ---------------- sqN wrap ----------------
    for (int s = 9; s < 126; s++) begin
      clear_in(); set_com(s);
      put_store(s, 32'h1000 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)), 1'b0);
      tick();
    end
    clear_in(); set_com(126);
    repeat (3) tick();
    chk("wrap_base_126", W'(sq_if.OUT_baseSqN), W'(126));
    for (int k = 0; k < 4; k++) begin
      clear_in(); put_store((126 + k) % MOD, 32'h600 + 32'(4 * k), $urandom, 4'hF, 1'b0); tick();
    end
    clear_in(); set_com(0);
    sq_if.IN_branchValid = 1'b1; sq_if.IN_branchSqN = sqn_t'(127);
    tick();
    clear_in();
    repeat (3) tick();
    chk("wrap_base_0", W'(sq_if.OUT_baseSqN), W'(0));
    chk("wrap_killed_empty", W'(sq_if.OUT_empty), W'(1));
    for (int k = 0; k < 2; k++) begin
      clear_in(); put_store(k, 32'h600 + 32'(4 * (k + 2)), $urandom, 4'hF, 1'b0); tick();
    end
    clear_in(); set_com(2);
    repeat (4) tick();
    chk("wrap_base_2", W'(sq_if.OUT_baseSqN), W'(2));

    // ---------------- reset during a pending request ----------------
    clear_in(); put_store(2, 32'h500, 32'hCAFE0002, 4'hF, 1'b0); tick();
    clear_in(); sq_if.IN_memReady = 1'b0; set_com(3); tick();
    chk("pre_rst_valid", W'(sq_if.OUT_memValid), W'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_drop_valid", W'(sq_if.OUT_memValid), W'(0));
    chk("rst_drop_base", W'(sq_if.OUT_baseSqN), W'(0));
    sq_if.IN_memReady = 1'b1;
    set_com(0);
    alloc = 0;

    // ---------------- random traffic ----------------
    for (int cyc = 0; cyc < 1500; cyc++) begin
      clear_in();
      wrote = 1'b0;
      new_alloc = alloc;
      sq_if.IN_memReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && sdiff(alloc, com) > 0)
        set_com(com + int'($urandom_range(1, sdiff(alloc, com))));
      if ($urandom_range(0, 9) < 6 && sdiff(alloc, m_base) < N) begin
        put_store(alloc, 32'h1000 + 32'(4 * $urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
        wrote = 1'b1;
        new_alloc = (alloc + 1) % MOD;
      end
      if ($urandom_range(0, 19) == 0) begin
        span = sdiff(alloc, com) + (wrote ? 1 : 0);
        br = (com - 1 + int'($urandom_range(0, span)) + MOD) % MOD;
        sq_if.IN_branchValid = 1'b1;
        sq_if.IN_branchSqN   = sqn_t'(br);
        new_alloc = (br + 1) % MOD;
      end
      if ($urandom_range(0, 1) == 1) begin
        ls = (m_base + int'($urandom_range(0, sdiff(alloc, m_base) + 1))) % MOD;
        sq_if.IN_ldValid = 1'b1;
        sq_if.IN_ldAddr  = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
        sq_if.IN_ldSqN   = sqn_t'(ls);
      end
      tick();
      alloc = new_alloc;
    end

    // ---------------- final drain ----------------
    clear_in(); sq_if.IN_memReady = 1'b1; set_com(alloc);
    repeat (20) tick();
    chk("final_sb_drained", W'(exp_q.size()), W'(0));
    chk("final_empty", W'(sq_if.OUT_empty), W'(1));
    chk("final_base", W'(sq_if.OUT_baseSqN), W'(alloc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
